// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Owns the PC, drives the
// combinational instruction memory and resolves jump/branch targets from IF/ID.
module fetch_stage #(
  parameter int                   PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter logic [31:0]          NOP_WORD = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                branch_taken,
  input  logic                jump,
  input  logic [31:0]         imem_instr,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_en,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc4,
  output logic                if_id_valid
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         if_id_instr_q, if_id_instr_d;
  logic [PC_WIDTH-1:0] if_id_pc4_q, if_id_pc4_d;
  logic                if_id_valid_q, if_id_valid_d;

  logic [PC_WIDTH-1:0] pc4, br_off, br_tgt, j_tgt;
  logic                jump_eff, branch_eff;

  always_comb begin
    pc4        = pc_q + PC_WIDTH'(4);
    br_off     = {{(PC_WIDTH-18){if_id_instr_q[15]}}, if_id_instr_q[15:0], 2'b00};
    br_tgt     = if_id_pc4_q + br_off;
    j_tgt      = {if_id_pc4_q[PC_WIDTH-1:28], if_id_instr_q[25:0], 2'b00};
    // A bubble in IF/ID never redirects, whatever ID drives.
    jump_eff   = jump & if_id_valid_q;
    branch_eff = branch_taken & if_id_valid_q;

    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;

    if (!stall) begin
      if (jump_eff)        pc_d = j_tgt;
      else if (branch_eff) pc_d = br_tgt;
      else                 pc_d = pc4;

      // Delay-slot word fetched alongside a redirect is latched normally.
      if_id_pc4_d   = pc4;
      if_id_instr_d = flush ? NOP_WORD : imem_instr;
      if_id_valid_d = ~flush;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP_WORD;
      if_id_pc4_q   <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_en     = reset & ~stall;
  assign pc          = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;

endmodule
